// File: rtl/multi_port_ram_latency.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_ram_latency
// Brief    : N-port synchronous RAM with independent programmable read and
//            write latency per port, a valid/ready request handshake, and
//            deterministic lowest-port-wins resolution of same-address write
//            collisions (flagged by wr_collision).
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_ram_latency #(
    parameter int                       N_PORTS       = 2,
    parameter int                       DATA_WIDTH    = 8,
    parameter int                       ADDRESS_WIDTH = 3,
    parameter logic [8*N_PORTS-1:0]     READ_LATENCY  = 16'h0302,
    parameter logic [8*N_PORTS-1:0]     WRITE_LATENCY = 16'h0403
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              req_valid,
    output logic [N_PORTS-1:0]              req_ready,
    input  logic [N_PORTS-1:0]              req_write,
    input  logic [N_PORTS*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   req_wdata,
    output logic [N_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [N_PORTS-1:0]              rd_valid,
    output logic                            wr_collision
);

    localparam int c_depth = 1 << ADDRESS_WIDTH;

    // Sequencer state encoding, shared by every port
    localparam logic c_idle = 1'b0;
    localparam logic c_busy = 1'b1;

    // Storage array; flops so that reset can clear every word
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    // Per-port completion view, gathered from the port generate blocks
    logic [N_PORTS-1:0]               w_due_write;
    logic [N_PORTS*ADDRESS_WIDTH-1:0] w_wr_addr;
    logic [N_PORTS*DATA_WIDTH-1:0]    w_wr_data;
    logic                             w_collision;
    logic                             r_wr_collision;

    generate
        for (genvar i = 0; i < N_PORTS; i++) begin : g_port
            // Only the low nibble carries the latency (legal range 1..15)
            localparam logic [3:0] c_rd_lat = READ_LATENCY[8*i +: 4];
            localparam logic [3:0] c_wr_lat = WRITE_LATENCY[8*i +: 4];

            logic                     r_state;
            logic                     w_state_nxt;
            logic [3:0]               r_cnt;
            logic [3:0]               w_cnt_nxt;
            logic                     r_due;
            logic                     w_due_nxt;
            logic                     w_accept;
            logic                     w_req_write;
            logic [ADDRESS_WIDTH-1:0] w_req_addr;
            logic [DATA_WIDTH-1:0]    w_req_wdata;
            logic [3:0]               w_lat;

            // Captured operation, held until its completion edge
            logic                     r_op_write;
            logic [ADDRESS_WIDTH-1:0] r_op_addr;
            logic [DATA_WIDTH-1:0]    r_op_wdata;
            logic [DATA_WIDTH-1:0]    r_op_rsample;

            logic [DATA_WIDTH-1:0]    r_rd_data;
            logic                     r_rd_valid;

            assign w_req_write = req_write[i];
            assign w_req_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign w_req_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            assign w_accept    = req_valid[i] && (r_state == c_idle);
            assign w_lat       = w_req_write ? c_wr_lat : c_rd_lat;

            // Next-state logic: a latency of L keeps the port busy for L-1
            // cycles; the operation completes on the edge after the count
            // expires, which is also the first edge a new request can land.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_due_nxt   = 1'b0;
                case (r_state)
                    c_idle: begin
                        if (w_accept) begin
                            if (w_lat > 4'd1) begin
                                w_state_nxt = c_busy;
                                w_cnt_nxt   = w_lat - 4'd1;
                            end else begin
                                w_due_nxt   = 1'b1;
                            end
                        end
                    end
                    c_busy: begin
                        w_cnt_nxt = r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            w_state_nxt = c_idle;
                            w_due_nxt   = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = c_idle;
                        w_cnt_nxt   = 4'd0;
                    end
                endcase
            end

            // Sequencer state, latency counter and completion strobe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= c_idle;
                    r_cnt   <= 4'd0;
                    r_due   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_due   <= w_due_nxt;
                end
            end

            // Capture the request; reads sample the array as it was before
            // this edge, so a write committing on the same edge is not seen
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_op_write   <= 1'b0;
                    r_op_addr    <= '0;
                    r_op_wdata   <= '0;
                    r_op_rsample <= '0;
                end else if (w_accept) begin
                    r_op_write   <= w_req_write;
                    r_op_addr    <= w_req_addr;
                    r_op_wdata   <= w_req_wdata;
                    r_op_rsample <= r_mem[w_req_addr];
                end
            end

            // Read return: pulse valid for one cycle, data holds otherwise
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= r_due && !r_op_write;
                    if (r_due && !r_op_write) begin
                        r_rd_data <= r_op_rsample;
                    end
                end
            end

            assign req_ready[i]                            = (r_state == c_idle);
            assign rd_valid[i]                             = r_rd_valid;
            assign rd_data[i*DATA_WIDTH +: DATA_WIDTH]     = r_rd_data;
            assign w_due_write[i]                          = r_due && r_op_write;
            assign w_wr_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = r_op_addr;
            assign w_wr_data[i*DATA_WIDTH +: DATA_WIDTH]   = r_op_wdata;
        end
    endgenerate

    // Array update: ports are visited highest-first so the lowest-index
    // port's non-blocking write is the last one and wins on a shared address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < c_depth; a++) begin
                r_mem[a] <= '0;
            end
        end else begin
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                if (w_due_write[p]) begin
                    r_mem[w_wr_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= w_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Detect two or more writes committing to one address on this edge
    always_comb begin
        w_collision = 1'b0;
        for (int a = 0; a < N_PORTS; a++) begin
            for (int b = a + 1; b < N_PORTS; b++) begin
                if (w_due_write[a] && w_due_write[b] &&
                    (w_wr_addr[a*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                     w_wr_addr[b*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
                    w_collision = 1'b1;
                end
            end
        end
    end

    // Register the collision flag for the cycle after the commit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_collision <= 1'b0;
        end else begin
            r_wr_collision <= w_collision;
        end
    end

    assign wr_collision = r_wr_collision;

endmodule
`default_nettype wire

// File: tb/tb_multi_port_ram_latency.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_port_ram_latency
// Brief    : Self-checking bench for multi_port_ram_latency. Two instances
//            (default latencies and a 1/15 latency sweep) share the stimulus;
//            a cycle model predicts ready, read data, commit order and
//            collisions, with read results queued at accept time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_port_ram_latency;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;

    logic [1:0]  ready_a, ready_b, rdv_a, rdv_b;
    logic [15:0] rdd_a, rdd_b;
    logic        coll_a, coll_b;

    logic        sel;
    logic [1:0]  obs_ready, obs_rdv;
    logic [15:0] obs_rdd;
    logic        obs_coll;

    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_rdv   = sel ? rdv_b   : rdv_a;
    assign obs_rdd   = sel ? rdd_b   : rdd_a;
    assign obs_coll  = sel ? coll_b  : coll_a;

    multi_port_ram_latency #(
        .N_PORTS(2), .DATA_WIDTH(8), .ADDRESS_WIDTH(3),
        .READ_LATENCY(16'h0302), .WRITE_LATENCY(16'h0403)
    ) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_data(rdd_a), .rd_valid(rdv_a), .wr_collision(coll_a)
    );

    multi_port_ram_latency #(
        .N_PORTS(2), .DATA_WIDTH(8), .ADDRESS_WIDTH(3),
        .READ_LATENCY(16'h0101), .WRITE_LATENCY(16'h0F01)
    ) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_data(rdd_b), .rd_valid(rdv_b), .wr_collision(coll_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_exp_t;

    typedef struct {
        int         due;
        int         port;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_pend_t;

    int         n_checks;
    int         n_errors;
    int         cyc;
    int         next_free [2];
    int         rl [2];
    int         wl [2];
    int         coll_seen;
    logic [7:0] mem_m [8];
    logic [7:0] last_rd [2];
    rd_exp_t    rq0 [$];
    rd_exp_t    rq1 [$];
    wr_pend_t   pw [$];

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (model cycle %0d)", tag, obs, exp, cyc);
        end
    endfunction

    task automatic drive(int p, logic wr, logic [2:0] addr, logic [7:0] data);
        req_valid[p]         = 1'b1;
        req_write[p]         = wr;
        req_addr[p*3 +: 3]   = addr;
        req_wdata[p*8 +: 8]  = data;
    endtask

    // One clock edge: predict, clock, compare. Entered and left at negedge.
    task automatic step();
        logic [1:0] acc;
        logic       exp_ready;
        logic       exp_v;
        logic       exp_coll;
        logic [2:0] a_p;
        int         wp [8];
        int         wc [8];
        logic [7:0] wd [8];
        rd_exp_t    e;
        wr_pend_t   w;
        wr_pend_t   keep [$];

        for (int p = 0; p < 2; p++) begin
            exp_ready = (cyc >= next_free[p]);
            chk($sformatf("req_ready[%0d]", p), 32'(obs_ready[p]), 32'(exp_ready));
            acc[p] = req_valid[p] && exp_ready;
        end

        // Reads see the model array before this edge's commits
        for (int p = 0; p < 2; p++) begin
            if (acc[p] && !req_write[p]) begin
                a_p    = req_addr[p*3 +: 3];
                e.data = mem_m[a_p];
                e.due  = cyc + rl[p];
                if (p == 0) rq0.push_back(e);
                else        rq1.push_back(e);
                next_free[p] = cyc + rl[p];
            end
        end

        // Commits due on this edge; lowest port wins per address
        for (int a = 0; a < 8; a++) begin
            wp[a] = 99;
            wc[a] = 0;
            wd[a] = 8'h00;
        end
        foreach (pw[k]) begin
            if (pw[k].due == cyc) begin
                wc[pw[k].addr]++;
                if (pw[k].port < wp[pw[k].addr]) begin
                    wp[pw[k].addr] = pw[k].port;
                    wd[pw[k].addr] = pw[k].data;
                end
            end else begin
                keep.push_back(pw[k]);
            end
        end
        pw = keep;
        exp_coll = 1'b0;
        for (int a = 0; a < 8; a++) begin
            if (wc[a] > 0) mem_m[a] = wd[a];
            if (wc[a] > 1) exp_coll = 1'b1;
        end

        for (int p = 0; p < 2; p++) begin
            if (acc[p] && req_write[p]) begin
                w.due  = cyc + wl[p];
                w.port = p;
                w.addr = req_addr[p*3 +: 3];
                w.data = req_wdata[p*8 +: 8];
                pw.push_back(w);
                next_free[p] = cyc + wl[p];
            end
        end

        @(posedge clk);
        @(negedge clk);

        for (int p = 0; p < 2; p++) begin
            exp_v = 1'b0;
            if (p == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin
                exp_v = 1'b1;
                last_rd[0] = rq0.pop_front().data;
            end
            if (p == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin
                exp_v = 1'b1;
                last_rd[1] = rq1.pop_front().data;
            end
            chk($sformatf("rd_valid[%0d]", p), 32'(obs_rdv[p]), 32'(exp_v));
            chk($sformatf("rd_data[%0d]", p), 32'(obs_rdd[p*8 +: 8]), 32'(last_rd[p]));
        end
        chk("wr_collision", 32'(obs_coll), 32'(exp_coll));
        if (obs_coll === 1'b1) coll_seen++;

        req_valid = 2'b00;
        cyc++;
    endtask

    // Asynchronous reset pulse straddling one edge; model state cleared
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("rst req_ready", 32'(obs_ready), 32'(2'b11));
        chk("rst rd_valid", 32'(obs_rdv), 32'(2'b00));
        chk("rst rd_data", 32'(obs_rdd), 32'(16'h0000));
        chk("rst wr_collision", 32'(obs_coll), 32'(1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        for (int a = 0; a < 8; a++) mem_m[a] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            next_free[p] = cyc;
            last_rd[p]   = 8'h00;
        end
        rq0.delete();
        rq1.delete();
        pw.delete();
        coll_seen = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tot, nr, nw, ni, guard, k;

        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        coll_seen = 0;
        rst       = 1'b1;
        sel       = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rl[0] = 2;  rl[1] = 3;
        wl[0] = 3;  wl[1] = 4;

        @(negedge clk);
        do_reset();

        // Ordering: port1 reads addr5 at offsets 2, 3, 4 from a port0 write
        for (int off = 2; off <= 4; off++) begin
            do_reset();
            drive(0, 1'b1, 3'd5, 8'hA5);
            step();
            repeat (off - 1) step();
            drive(1, 1'b0, 3'd5, 8'h00);
            step();
            repeat (6) step();
            chk($sformatf("order off%0d result", off), 32'(last_rd[1]),
                32'((off == 4) ? 8'hA5 : 8'h00));
        end

        // Collision: both writes commit to addr2 on the same edge
        do_reset();
        drive(1, 1'b1, 3'd2, 8'h22);
        step();
        drive(0, 1'b1, 3'd2, 8'h11);
        step();
        repeat (4) step();
        drive(0, 1'b0, 3'd2, 8'h00);
        step();
        repeat (4) step();
        chk("collision pulses", 32'(coll_seen), 32'(1));
        chk("collision winner", 32'(last_rd[0]), 32'(8'h11));

        // Back-to-back reads on port0 with valid held high
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive(0, 1'b0, 3'(n), 8'h00);
            step();
        end
        repeat (3) step();

        // Reset mid-operation discards a pending write and a pending read
        do_reset();
        drive(1, 1'b1, 3'd7, 8'hFF);
        step();
        drive(0, 1'b0, 3'd7, 8'h00);
        step();
        do_reset();
        drive(0, 1'b0, 3'd7, 8'h00);
        step();
        repeat (4) step();
        chk("reset-op read addr7", 32'(last_rd[0]), 32'(8'h00));

        // Latency sweep on the second instance
        sel   = 1'b1;
        rl[0] = 1;  rl[1] = 1;
        wl[0] = 1;  wl[1] = 15;
        do_reset();
        drive(0, 1'b1, 3'd1, 8'h3C);
        drive(1, 1'b1, 3'd6, 8'h77);
        step();
        drive(0, 1'b0, 3'd1, 8'h00);
        step();
        chk("sweep early read", 32'(last_rd[0]), 32'(8'h00));
        drive(0, 1'b0, 3'd1, 8'h00);
        step();
        step();
        chk("sweep p0 commit", 32'(last_rd[0]), 32'(8'h3C));
        for (int n = 0; n < 11; n++) begin
            drive(1, 1'b0, 3'd0, 8'h00);
            step();
        end
        drive(0, 1'b0, 3'd6, 8'h00);
        step();
        drive(0, 1'b0, 3'd6, 8'h00);
        step();
        step();
        chk("sweep p1 commit", 32'(last_rd[0]), 32'(8'h77));
        repeat (3) step();

        // Random soak on the default instance
        sel   = 1'b0;
        rl[0] = 2;  rl[1] = 3;
        wl[0] = 3;  wl[1] = 4;
        do_reset();
        tot = 0; nr = 0; nw = 0; ni = 0; guard = 0;
        while (tot < 200 && guard < 5000) begin
            for (int p = 0; p < 2; p++) begin
                if (cyc >= next_free[p] && tot < 200) begin
                    k = $urandom_range(0, 2);
                    if (k == 0) begin
                        drive(p, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                        nw++;
                    end else if (k == 1) begin
                        drive(p, 1'b0, 3'($urandom_range(0, 7)), 8'h00);
                        nr++;
                    end else begin
                        ni++;
                    end
                    tot++;
                end else if ($urandom_range(0, 1) == 1) begin
                    drive(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                end
            end
            step();
            guard++;
        end
        repeat (20) step();
        chk("soak completed", 32'(tot), 32'(200));
        $display("soak: %0d reads, %0d writes, %0d idles, %0d total", nr, nw, ni, tot);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_port_ram_latency.md
Name: multi_port_ram_latency

Overview:
- Parametrised N-port synchronous RAM; each port has its own programmable read and write latency.
- Successor to the fixed two-port latency RAM. Adds:
  - arbitrary port count;
  - a valid/ready request handshake per port;
  - deterministic same-address write-collision resolution with a flag;
  - an in-flight pipeline that can be cancelled by reset.
- Sits as the DUT under the pkg-based class environment: generator, driver, reference model, monitor, scoreboard.

Parameters:
- N_PORTS, 2: number of independent ports, 1..8.
- DATA_WIDTH, 8: data word width in bits.
- ADDRESS_WIDTH, 3: address width; depth = 2**ADDRESS_WIDTH.
- READ_LATENCY, 16'h0302: packed 8-bit per port; port i latency is [8i+7:8i], range 1..15. Default: port0=2, port1=3.
- WRITE_LATENCY, 16'h0403: packed 8-bit per port, same layout. Default: port0=3, port1=4.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_PORTS  per-port request valid.
- req_ready  output  N_PORTS  per-port ready to accept a request.
- req_write  input  N_PORTS  1 = write, 0 = read; qualified by req_valid.
- req_addr  input  N_PORTS*ADDRESS_WIDTH  per-port address; port i uses slice i.
- req_wdata  input  N_PORTS*DATA_WIDTH  per-port write data.
- rd_data  output  N_PORTS*DATA_WIDTH  per-port read data.
- rd_valid  output  N_PORTS  one-cycle pulse qualifying rd_data.
- wr_collision  output  1  pulse when two or more writes commit to the same address on the same edge.

Behaviour:
- Reset (async, rst=1):
  - all memory words = 0;
  - req_ready = all 1s; rd_valid = 0; rd_data = 0; wr_collision = 0;
  - all in-flight operations discarded and all latency counters cleared.
  - Requests presented while rst=1 are ignored.
- Accept: port i accepts at edge E when req_valid[i] && req_ready[i]. Address, data and op are captured at E.
- Per-port sequencer, two states:
  - IDLE -> BUSY on accept, loading counter = L − 1, where L = READ_LATENCY[i] or WRITE_LATENCY[i].
  - BUSY decrements each edge and returns to IDLE when the counter hits 0.
  - req_ready[i] = 1 in IDLE, 0 in BUSY.
  - Consequence: next accept is possible at edge E+L, giving one op per L cycles. With L=1 the port never goes busy.
- Write accepted at E: the word commits at edge E+L and is visible to reads accepted at E+L+1 or later.
- Read accepted at E:
  - samples the array as it stands before edge E, so it does not see a write committing at the same edge E (read-before-write);
  - rd_data[i] is registered, and rd_valid[i] = 1 for exactly the cycle following edge E+L;
  - rd_data holds its last value when rd_valid = 0.
- Multiple writes committing on the same edge to the same address:
  - the lowest-index port wins;
  - wr_collision = 1 for the cycle following that edge.
- Writes to different addresses on the same edge all commit; no flag.
- Reads never collide. Any number of ports may read any address concurrently.
- req_valid=0 leaves a port idle with no side effects. req_write/addr/wdata are don't-care when not accepted.
- Reset mid-operation: pending writes never commit and pending reads never produce rd_valid. After release, all ports are IDLE.
- Address arithmetic is unsigned with no wrap logic; every address in 0..2**ADDRESS_WIDTH−1 is valid.

Test Plan:
1. Ordering, with E0 = port0 write addr5=8'hA5 (commits at E0+3):
   - port1 read addr5 accepted at E0+2 -> rd_valid[1] after E0+5 with 8'h00;
   - port1 read addr5 accepted at E0+3 -> 8'h00 (read-before-write at the commit edge);
   - port1 read addr5 accepted at E0+4 -> 8'hA5.
2. Collision:
   - port1 write addr2=8'h22 at E, port0 write addr2=8'h11 at E+1; both commit at E+4;
   - -> wr_collision pulses once, and a later read of addr2 returns 8'h11.
3. Back-to-back on port0:
   - read accepted at E with req_valid held high -> req_ready[0] = 0 for one cycle, next accept at E+2, one rd_valid pulse per accept.
4. Reset mid-op:
   - port1 write addr7=8'hFF at E, rst pulsed at E+2 -> no commit, read addr7 returns 8'h00, req_ready = 2'b11, no spurious rd_valid.
5. Latency sweep:
   - rebuild with READ_LATENCY=16'h0101 and WRITE_LATENCY=16'h0F01 -> port0 write commits after 1 edge, port1 after 15 edges, matching the reference model.
6. Random soak:
   - 200 mixed WRITE/READ/IDLE transactions on both ports over all 8 addresses -> scoreboard reports 0 failures, and read/write/idle counts sum to the total.
